// File: rtl/xgmii_tx_arbiter.sv
// xgmii_tx_arbiter: round-robin frame arbiter of two FWFT FIFOs onto a
// registered XGMII TX port. Ports: sys_clk, sys_rst (async, active-high),
// fifoN_dout/fifoN_empty/fifoN_rd_en (N=0,1; word = {txc,txd}),
// xgmii_txd/xgmii_txc (registered), grant (owner of the word on the wire),
// drop_cnt (saturating count of non-start words discarded while idle).
// Optional macro TX_ARB_IFG_EN: two IDLE words of gap after every TERM.
module xgmii_tx_arbiter (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] fifo0_dout,
  input  logic        fifo0_empty,
  output logic        fifo0_rd_en,
  input  logic [71:0] fifo1_dout,
  input  logic        fifo1_empty,
  output logic        fifo1_rd_en,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  grant,
  output logic [15:0] drop_cnt
);

  localparam logic [71:0] IDLE_W = {8'hFF, {8{8'h07}}};
  localparam logic [71:0] ERR_W  = {8'hFF, {8{8'hFE}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  function automatic logic is_start(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic logic is_term(input logic [71:0] w);
    logic t;
    t = 1'b0;
    for (int k = 0; k < 8; k++)
      if (w[64+k] && (w[8*k +: 8] == 8'hFD))
        t = 1'b1;
    return t;
  endfunction

  state_t      state_q, state_d;
  // Source of the most recent grant; also the owner while in SEND.
  logic        last_q, last_d;
  logic [1:0]  grant_d;
  logic [71:0] tx_d;
  logic [15:0] drop_d;
  logic [16:0] drop_sum;
  logic [1:0]  drops;
  logic        rd0, rd1;
  logic [71:0] head;
  logic        head_empty;
  logic        st0, st1;
  logic        pick0, pick1;
`ifdef TX_ARB_IFG_EN
  logic        gap_q, gap_d;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = 2'b00;
    tx_d       = IDLE_W;
    drops      = 2'd0;
    rd0        = 1'b0;
    rd1        = 1'b0;
`ifdef TX_ARB_IFG_EN
    gap_d      = 1'b0;
`endif
    head       = last_q ? fifo1_dout : fifo0_dout;
    head_empty = last_q ? fifo1_empty : fifo0_empty;
    st0        = !fifo0_empty && is_start(fifo0_dout);
    st1        = !fifo1_empty && is_start(fifo1_dout);
    pick0      = st0 && (!st1 || last_q);
    pick1      = st1 && (!st0 || !last_q);

    case (state_q)
      S_IDLE: begin
        // Garbage heads are flushed in parallel with arbitration.
        if (!fifo0_empty && !st0) begin
          rd0   = 1'b1;
          drops = drops + 2'd1;
        end
        if (!fifo1_empty && !st1) begin
          rd1   = 1'b1;
          drops = drops + 2'd1;
        end
        unique case (1'b1)
          pick0: begin
            rd0     = 1'b1;
            last_d  = 1'b0;
            grant_d = 2'b01;
            tx_d    = fifo0_dout;
            state_d = S_SEND;
          end
          pick1: begin
            rd1     = 1'b1;
            last_d  = 1'b1;
            grant_d = 2'b10;
            tx_d    = fifo1_dout;
            state_d = S_SEND;
          end
          default: ;
        endcase
      end
      S_SEND: begin
        grant_d = last_q ? 2'b10 : 2'b01;
        if (head_empty) begin
          tx_d = ERR_W;
        end else begin
          if (last_q) rd1 = 1'b1;
          else        rd0 = 1'b1;
          // A fresh START inside a frame marks it corrupted.
          if (is_start(head)) begin
            tx_d = ERR_W;
          end else begin
            tx_d = head;
            if (is_term(head)) begin
`ifdef TX_ARB_IFG_EN
              state_d = S_GAP;
`else
              state_d = S_IDLE;
`endif
            end
          end
        end
      end
`ifdef TX_ARB_IFG_EN
      S_GAP: begin
        gap_d = 1'b1;
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    drop_sum = {1'b0, drop_cnt} + {15'd0, drops};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // No pops may leak out while reset holds the registers.
    if (sys_rst) begin
      rd0 = 1'b0;
      rd1 = 1'b0;
    end
  end

  assign fifo0_rd_en = rd0;
  assign fifo1_rd_en = rd1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      grant     <= 2'b00;
      xgmii_txd <= IDLE_W[63:0];
      xgmii_txc <= IDLE_W[71:64];
      drop_cnt  <= 16'd0;
`ifdef TX_ARB_IFG_EN
      gap_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant     <= grant_d;
      xgmii_txd <= tx_d[63:0];
      xgmii_txc <= tx_d[71:64];
      drop_cnt  <= drop_d;
`ifdef TX_ARB_IFG_EN
      gap_q     <= gap_d;
`endif
    end
  end

endmodule

// File: doc/xgmii_tx_arbiter.md
XGMII_TX_ARBITER -- requirements
Module: xgmii_tx_arbiter

Interface
REQ-001 The block SHALL have no parameters; all sizing is fixed: FIFO word 72 bits = {txc[7:0], txd[63:0]}.
REQ-002 The block SHALL have port sys_clk  in  1  the single clock for all logic.
REQ-003 The block SHALL have port sys_rst  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have ports fifoN_dout  in  72  head word of source FIFO N (N=0,1), FWFT, valid when !fifoN_empty.
REQ-005 The block SHALL have ports fifoN_empty  in  1  source FIFO N empty.
REQ-006 The block SHALL have ports fifoN_rd_en  out  1  pop head of FIFO N; asserted only when fifoN_empty=0.
REQ-007 The block SHALL have port xgmii_txd  out  64  registered XGMII TX data.
REQ-008 The block SHALL have port xgmii_txc  out  8  registered XGMII TX control.
REQ-009 The block SHALL have port grant  out  2  one-hot owner of current frame (01=src0, 10=src1, 00=none).
REQ-010 The block SHALL have port drop_cnt  out  16  saturating count of non-start head words discarded in IDLE.

Function
REQ-011 Definitions: IDLE word = txd 64'h0707070707070707, txc 8'hFF; ERROR word = txd 64'hFEFEFEFEFEFEFEFE, txc 8'hFF; START word = lane0 8'hFB with txc[0]=1; TERM word = any lane k with txc[k]=1 and data 8'hFD.
REQ-012 The block SHALL implement FSM states IDLE, SEND, GAP.
REQ-013 IDLE: if a head word is non-empty and not START, it SHALL be popped, not transmitted, and drop_cnt incremented (saturate at 16'hFFFF); both sources MAY be dropped in the same cycle.
REQ-014 IDLE: if one or more heads are START, the block SHALL grant by round-robin (priority to the source not granted last; src0 first after reset), pop that word, and enter SEND.
REQ-015 A non-granted START head SHALL NOT be popped or dropped while the other source is granted.
REQ-016 SEND: each cycle the granted FIFO is non-empty, its head SHALL be popped and driven to XGMII on the next cycle (latency 1 register stage).
REQ-017 SEND: if the granted FIFO is empty, the output SHALL be ERROR word for that cycle; the FSM SHALL stay in SEND.
REQ-018 SEND: popping a TERM word SHALL move to GAP (macro defined) or IDLE (macro undefined); grant SHALL clear when leaving SEND.
REQ-019 A START word popped in SEND (no prior TERM) SHALL be transmitted as ERROR word and the FSM SHALL stay in SEND (frame treated as corrupted).
REQ-020 Whenever no word is popped for transmission, the output SHALL be IDLE word.
REQ-021 Only the granted source SHALL be popped in SEND/GAP; fifoN_rd_en SHALL never be asserted with fifoN_empty=1.

Reset
REQ-022 On sys_rst=1 (asynchronous), state SHALL be IDLE, xgmii_txd/txc SHALL be IDLE word, grant=00, fifo0/1_rd_en=0, drop_cnt=0, round-robin pointer=src1-last (so src0 wins first).
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; no TERM is generated; after release, arbitration restarts in IDLE.

Configuration
REQ-024 Macro TX_ARB_IFG_EN: when defined, GAP state SHALL emit exactly 2 IDLE words after the TERM word before returning to IDLE, no pops during GAP; when undefined, GAP is absent and the next START may be popped the cycle after TERM is popped.

Verification
REQ-025 Reset, both FIFOs empty -> continuous IDLE words, grant=00, rd_en both 0, drop_cnt=0.
REQ-026 src0 holds 1 frame START,D,D,TERM(lane3) -> same 4 words on XGMII one cycle after each pop, grant=01 for 4 cycles, then IDLE.
REQ-027 Both sources present START the same cycle, repeatedly -> frames alternate src0, src1, src0; with TX_ARB_IFG_EN exactly 2 IDLE words between frames, without it 0.
REQ-028 src1 head = 3 IDLE words then START frame -> 3 pops discarded, drop_cnt=3, frame then forwarded intact.
REQ-029 src0 goes empty for 2 cycles mid-frame -> 2 ERROR words inserted, remainder of frame follows, grant held 01.
REQ-030 sys_rst pulsed for 1 cycle mid-frame -> outputs IDLE asynchronously, grant=00; after release, next START arbitrated with src0 priority.
